// File: rtl/vend_pkg.sv
// Shared constants for the vend front end: button channel map and debounce depths.
package vend_pkg;

    localparam int N_CH       = 3;
    localparam int CH_COIN50  = 0;
    localparam int CH_COIN100 = 1;
    localparam int CH_CONFIRM = 2;

    localparam int DEBOUNCE_CYCLES_SYN = 16;
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    typedef logic [N_CH-1:0] btn_vec_t;

endpackage

// File: rtl/debounce_channel.sv
// One button line: 2-FF synchronizer, counter debounce, clean level and press pulse.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic pulse,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             ff1;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             qualify;

    assign qualify = (s != level) && (cnt == CNT_MAX);
    // rise feeds the top-level any_pulse register so it lines up with pulse
    assign rise    = qualify && s;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1   <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            ff1   <= btn_in;
            s     <= ff1;
            pulse <= rise;
            if (s == level) begin
                cnt <= '0;
            end else if (qualify) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/coin_key_debouncer.sv
// Debounces the coin-50, coin-100 and confirm buttons ahead of the vend FSM.
module coin_key_debouncer #(
    parameter int N_CH            = vend_pkg::N_CH,
    parameter int DEBOUNCE_CYCLES = vend_pkg::DEBOUNCE_CYCLES_SYN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_pulse,
    output logic            any_pulse
);

    logic [N_CH-1:0] rise;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .btn_in (btn_in[i]),
            .level  (btn_level[i]),
            .pulse  (btn_pulse[i]),
            .rise   (rise[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_pulse <= 1'b0;
        end else begin
            any_pulse <= |rise;
        end
    end

endmodule
